date_counter: RTL and testbench
===============================

Name: date_counter

Overview:
- Calendar counter on the receiving end of the time block's day-rollover pulse. Consumes `clk_day`, a 1-cycle pulse at 11:59:59 PM→midnight, and keeps year/month/day.
- Accepts the same style of per-field increment/decrement push-button requests as the time block, for user setting.
- Emits a 1-cycle `clk_year` pulse on year rollover for downstream display/alarm logic.
- Covers years 2000–2099, stored as offset 0–99.

Parameters:
RESET_YEAR, 0, year offset loaded on reset (0..99)
RESET_MONTH, 1, month loaded on reset (1..12)
RESET_DAY, 1, day loaded on reset (1..31, must be valid for RESET_MONTH/RESET_YEAR)
RESET_WDAY, 6, weekday loaded on reset (0=Sun..6=Sat; 2000-01-01 = Sat); used only with WEEKDAY_EN

Ports:
clk  in  1  system clock (1 kHz, shared with time block)
rst  in  1  synchronous reset, active-high
clk_day  in  1  1-cycle day-advance pulse from time block
i_y, i_mo, i_d  in  1 each  increment request, level from debounced button
d_y, d_mo, d_d  in  1 each  decrement request, level from debounced button
year  out  7  year offset 0..99
month  out  4  1..12
day  out  5  1..31
clk_year  out  1  1-cycle pulse when year advances via clk_day carry
wday  out  3  weekday 0..6 (present only with WEEKDAY_EN)

Behaviour:
- Reset: the design uses one clock; reset is synchronous and active-high. On reset: year=RESET_YEAR, month=RESET_MONTH, day=RESET_DAY, clk_year=0. All edge-detect and pending registers clear.
- Month length: a combinational function of (month, year).
  - 31 days: months 1,3,5,7,8,10,12.
  - 30 days: months 4,6,9,11.
  - Month 2: 29 if year[1:0]==0, else 28. Valid for the whole 2000–2099 range.
- Tick (clk_day==1), same-cycle update, highest priority:
  - If day < len: day+1.
  - Else day=1, and:
    - if month < 12: month+1;
    - else month=1 and year advances: 99 wraps to 0.
  - clk_year=1 in the cycle after a year advance, i.e. registered together with the new year value. Otherwise clk_year=0.
- Manual requests:
  - Each of the six inputs is rising-edge detected using one register per input.
  - A detected edge sets that field's pending-inc or pending-dec flag.
  - Pending flags are applied in the first cycle with clk_day==0, then cleared.
  - If a tick coincides with pending flags, the flags are held and applied next cycle.
  - If inc and dec are both pending for one field in the same cycle, both clear and the field is unchanged.
- Manual field rules. Manual changes never carry into other fields and never produce clk_year.
  - day: inc wraps len→1; dec wraps 1→len.
  - month: inc wraps 12→1; dec wraps 1→12.
  - year: inc wraps 99→0; dec wraps 0→99.
- Day clamp: after a month or year change, if day > new len then day=len, in the same cycle. Examples: 31 Mar with dec month → 29 Feb in year 0; 29 Feb 2004 with inc year → 28 Feb.
- Multiple fields pending in one cycle are applied in the order year, month, day. The clamp uses the final month/year.
- Reset mid-request: pending flags clear. A button still held after reset deasserts does not generate an edge.

Optional Feature:
WEEKDAY_EN
- Defined:
  - `wday` port and register exist; reset value RESET_WDAY.
  - Advances 6→0 on every clk_day tick.
  - Manual day inc/dec also moves wday ±1 modulo 7.
  - Manual month/year changes leave wday unchanged; the user re-syncs via day adjust.
- Undefined: no `wday` port or logic. All other behaviour is identical.

Decomposition:
- Shared package `watch_pkg` holds:
  - month constants JAN..DEC;
  - day-count constants 28/29/30/31;
  - the weekday enum SUN..SAT;
  - the year-offset max (99).
- One sub-module, `month_len`: combinational (month, year) → 5-bit day count. It is reused later by the display/alarm blocks.
- Edge detection stays inline.

Test Plan:
- Reset with defaults → year=0, month=1, day=1, clk_year=0. With WEEKDAY_EN, wday=6.
- Preset 0/2/28 (2000-02-28), then pulse clk_day twice → 02-29, then 03-01. For year=1, a single pulse from 02-28 → 03-01.
- Set 99/12/31, pulse clk_day → 0/1/1, and clk_year high for exactly one cycle. Pulse again from 0/6/30 → 0/7/1 with clk_year=0.
- Hold i_d high for 50 cycles from day 31 (Jan) → day=1, month still 1; exactly one increment. Pulse d_d at day=1 → day=31.
- At 0/3/31 pulse d_mo → 0/2/29. Then pulse i_y → 1/2/28. Assert i_d and d_d together → day unchanged.
- Raise i_d in the same cycle as clk_day at 0/1/10 → tick gives 01-11, then the manual inc gives 01-12 one cycle later. Assert rst while a request is pending → reset values, and no change after release.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: shared calendar constants and weekday enum for the watch blocks
package watch_pkg;
  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;
  localparam logic [4:0] D28 = 5'd28;
  localparam logic [4:0] D29 = 5'd29;
  localparam logic [4:0] D30 = 5'd30;
  localparam logic [4:0] D31 = 5'd31;
  localparam logic [6:0] YEAR_MAX = 7'd99;
  typedef enum logic [2:0] {SUN, MON, TUE, WED, THU, FRI, SAT} wday_e;
endpackage

// File: rtl/month_len.sv
// month_len: days in (month, year offset); leap rule year%4==0 holds across 2000-2099
module month_len
  import watch_pkg::*;
(
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] len
);
  logic unused_year;
  assign unused_year = ^year[6:2];
  always_comb
    len = (month == FEB) ? ((year[1:0] == 2'd0) ? D29 : D28) :
          (month == APR || month == JUN || month == SEP || month == NOV) ? D30 : D31;
endmodule

// File: rtl/date_counter.sv
// date_counter: year/month/day calendar driven by clk_day with button setting;
// define WEEKDAY_EN to add the wday weekday register and port.
module date_counter
  import watch_pkg::*;
#(
  parameter int RESET_YEAR  = 0,
  parameter int RESET_MONTH = 1,
  parameter int RESET_DAY   = 1,
  parameter int RESET_WDAY  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_day,
  input  logic       i_y,
  input  logic       i_mo,
  input  logic       i_d,
  input  logic       d_y,
  input  logic       d_mo,
  input  logic       d_d,
  output logic [6:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic       clk_year
`ifdef WEEKDAY_EN
  ,
  output logic [2:0] wday
`endif
);
  logic [6:0] year_q, year_d, y_m, y_inc;
  logic [3:0] month_q, month_d, m_m;
  logic [4:0] day_q, day_d, d_c, d_m, len_c, len_n;
  logic       clk_year_q, clk_year_d, last_d, last_m;
  logic [5:0] btn, prev_q, rise, pend_q, pend_d;
  logic [2:0] inc, dec;
  month_len u_len_c (.month(month_q), .year(year_q), .len(len_c));
  month_len u_len_n (.month(m_m), .year(y_m), .len(len_n));
  assign btn = {d_d, d_mo, d_y, i_d, i_mo, i_y};
  assign rise = btn & ~prev_q;
  assign inc = pend_q[2:0] & ~pend_q[5:3];
  assign dec = pend_q[5:3] & ~pend_q[2:0];
  assign y_inc = (year_q == YEAR_MAX) ? 7'd0 : year_q + 7'd1;
  always_comb begin
    y_m = inc[0] ? y_inc : dec[0] ? ((year_q == 7'd0) ? YEAR_MAX : year_q - 7'd1) : year_q;
    m_m = inc[1] ? ((month_q == DEC) ? JAN : month_q + 4'd1) :
          dec[1] ? ((month_q == JAN) ? DEC : month_q - 4'd1) : month_q;
    d_c = (day_q > len_n) ? len_n : day_q;
    d_m = inc[2] ? ((d_c == len_n) ? 5'd1 : d_c + 5'd1) :
          dec[2] ? ((d_c == 5'd1) ? len_n : d_c - 5'd1) : d_c;
    last_d = (day_q == len_c);
    last_m = (month_q == DEC);
    year_d = clk_day ? ((last_d && last_m) ? y_inc : year_q) : y_m;
    month_d = clk_day ? (last_d ? (last_m ? JAN : month_q + 4'd1) : month_q) : m_m;
    day_d = clk_day ? (last_d ? 5'd1 : day_q + 5'd1) : d_m;
    clk_year_d = clk_day && last_d && last_m;
    pend_d = clk_day ? (pend_q | rise) : rise;
  end
  // prev_q tracks buttons even in reset so a button held through reset gives no edge
  always_ff @(posedge clk) begin
    prev_q <= btn;
    if (rst) begin
      year_q <= 7'(RESET_YEAR);
      month_q <= 4'(RESET_MONTH);
      day_q <= 5'(RESET_DAY);
      clk_year_q <= 1'b0;
      pend_q <= '0;
    end else begin
      year_q <= year_d;
      month_q <= month_d;
      day_q <= day_d;
      clk_year_q <= clk_year_d;
      pend_q <= pend_d;
    end
  end
  assign year = year_q;
  assign month = month_q;
  assign day = day_q;
  assign clk_year = clk_year_q;
`ifdef WEEKDAY_EN
  logic [2:0] wday_q, wday_d, w_inc, w_dec;
  always_comb begin
    w_inc = (wday_q == 3'(SAT)) ? 3'(SUN) : wday_q + 3'd1;
    w_dec = (wday_q == 3'(SUN)) ? 3'(SAT) : wday_q - 3'd1;
    wday_d = clk_day ? w_inc : inc[2] ? w_inc : dec[2] ? w_dec : wday_q;
  end
  always_ff @(posedge clk) begin
    if (rst) wday_q <= 3'(RESET_WDAY);
    else wday_q <= wday_d;
  end
  assign wday = wday_q;
`endif
endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: directed scoreboard bench for date_counter
module tb_date_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_day = 1'b0;
  logic [5:0] btn = '0;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic       clk_year;
`ifdef WEEKDAY_EN
  logic [2:0] wday;
`endif
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int wd = 6;
  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] y;
    logic [3:0] m;
    logic [4:0] d;
    logic       cy;
    logic [2:0] w;
  } exp_t;
  exp_t q[$];
  date_counter dut (
    .clk(clk), .rst(rst), .clk_day(clk_day),
    .i_y(btn[0]), .i_mo(btn[1]), .i_d(btn[2]),
    .d_y(btn[3]), .d_mo(btn[4]), .d_d(btn[5]),
    .year(year), .month(month), .day(day), .clk_year(clk_year)
`ifdef WEEKDAY_EN
    , .wday(wday)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || year != e.y || month != e.m || day != e.d || clk_year != e.cy) begin
        failures++;
        $display("FAIL %s: got %0d/%0d/%0d clk_year=%0d, want %0d/%0d/%0d clk_year=%0d",
                 e.tag, year, month, day, clk_year, e.y, e.m, e.d, e.cy);
      end
`ifdef WEEKDAY_EN
      checks++;
      if (wday != e.w) begin
        failures++;
        $display("FAIL %s wday: got %0d, want %0d", e.tag, wday, e.w);
      end
`endif
    end
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(string tag, int y, int m, int d, int cy);
    q.push_back('{cyc, tag, 7'(y), 4'(m), 5'(d), 1'(cy), 3'(wd)});
  endtask
  task automatic press(int b);
    btn[b] = 1'b1;
    step();
    btn[b] = 1'b0;
    step();
    if (b == 2) wd = (wd + 1) % 7;
    if (b == 5) wd = (wd + 6) % 7;
  endtask
  task automatic tick();
    clk_day = 1'b1;
    step();
    clk_day = 1'b0;
    wd = (wd + 1) % 7;
  endtask
  initial begin
    step(3);
    rst = 1'b0;
    step();
    push("reset", 0, 1, 1, 0);
    press(1);
    press(5);
    press(5);
    push("preset_0228", 0, 2, 28, 0);
    tick();
    push("tick_0229", 0, 2, 29, 0);
    tick();
    push("tick_0301", 0, 3, 1, 0);
    press(0);
    press(4);
    press(5);
    push("preset_y1_0228", 1, 2, 28, 0);
    tick();
    push("tick_y1_0301", 1, 3, 1, 0);
    press(3);
    press(3);
    press(4);
    press(4);
    press(4);
    press(5);
    push("preset_99_1231", 99, 12, 31, 0);
    tick();
    push("year_wrap", 0, 1, 1, 1);
    step();
    push("clk_year_one_cycle", 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) press(1);
    press(5);
    push("preset_0630", 0, 6, 30, 0);
    tick();
    push("tick_0701", 0, 7, 1, 0);
    for (int i = 0; i < 6; i++) press(4);
    press(5);
    push("preset_0131", 0, 1, 31, 0);
    btn[2] = 1'b1;
    step(50);
    btn[2] = 1'b0;
    step(2);
    wd = (wd + 1) % 7;
    push("held_inc_once", 0, 1, 1, 0);
    press(5);
    push("dec_day_wrap", 0, 1, 31, 0);
    press(1);
    push("inc_month_clamp", 0, 2, 29, 0);
    press(1);
    press(2);
    press(2);
    push("preset_0331", 0, 3, 31, 0);
    press(4);
    push("dec_month_clamp", 0, 2, 29, 0);
    press(0);
    push("inc_year_clamp", 1, 2, 28, 0);
    btn[2] = 1'b1;
    btn[5] = 1'b1;
    step();
    btn[2] = 1'b0;
    btn[5] = 1'b0;
    step(2);
    push("inc_dec_cancel", 1, 2, 28, 0);
    press(3);
    press(4);
    for (int i = 0; i < 18; i++) press(5);
    push("preset_0110", 0, 1, 10, 0);
    btn[2] = 1'b1;
    tick();
    btn[2] = 1'b0;
    push("tick_with_edge", 0, 1, 11, 0);
    step();
    wd = (wd + 1) % 7;
    push("deferred_inc", 0, 1, 12, 0);
    btn[2] = 1'b1;
    step();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    wd = 6;
    step(5);
    push("reset_pending_held", 0, 1, 1, 0);
    btn[2] = 1'b0;
    step(3);
    push("after_release", 0, 1, 1, 0);
    step(3);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
